// File: rtl/alu_share_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_share_arbiter : two-port round-robin share of one combinational ALU, |
// | registered tagged response. Optional stats: ALU_ARB_STATS_EN.  Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_in1,
  input  logic [31:0] i_in2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  output logic [31:0] o_out
);
  logic [4:0]  w_shamt;
  logic        w_alt;
  logic [31:0] w_sra;
  logic        w_unused;

  assign w_unused = i_clk ^ i_rst;
  assign w_shamt  = i_in2[4:0];
  assign w_alt    = (i_funct7 == 7'h20);
  // Kept in its own signed context so the shift stays arithmetic.
  assign w_sra    = $signed(i_in1) >>> w_shamt;

  always_comb begin
    o_out = '0;
    case (i_funct3)
      3'd0: o_out = w_alt ? (i_in1 - i_in2) : (i_in1 + i_in2);
      3'd1: o_out = i_in1 << w_shamt;
      3'd2: o_out = {31'b0, $signed(i_in1) < $signed(i_in2)};
      3'd3: o_out = {31'b0, i_in1 < i_in2};
      3'd4: o_out = i_in1 ^ i_in2;
      3'd5: o_out = w_alt ? w_sra : (i_in1 >> w_shamt);
      3'd6: o_out = i_in1 | i_in2;
      3'd7: o_out = i_in1 & i_in2;
      default: o_out = '0;
    endcase
  end
endmodule

module alu_share_arbiter #(
  parameter int START_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [2:0]  req0_funct3,
  input  logic [6:0]  req0_funct7,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic [2:0]  req1_funct3,
  input  logic [6:0]  req1_funct7,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);
  localparam logic c_START_PRIO = (START_PRIO != 0);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_prio;
  logic [31:0] r_data;
  logic        r_id;
  logic        w_can_accept, w_gnt_any, w_gnt_id, w_accept;
  logic [31:0] w_in1, w_in2, w_alu_out;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;

  assign w_can_accept = (r_state == EMPTY) || rsp_ready;
  assign w_gnt_any    = req0_valid || req1_valid;
  assign w_gnt_id     = (req0_valid && req1_valid) ? r_prio : req1_valid;
  assign w_accept     = !rst && w_can_accept && w_gnt_any;
  assign req0_ready   = w_accept && !w_gnt_id;
  assign req1_ready   = w_accept && w_gnt_id;

  // With no grant w_gnt_id is 0, so port 0 drives the ALU by default.
  assign w_in1    = w_gnt_id ? req1_in1    : req0_in1;
  assign w_in2    = w_gnt_id ? req1_in2    : req0_in2;
  assign w_funct3 = w_gnt_id ? req1_funct3 : req0_funct3;
  assign w_funct7 = w_gnt_id ? req1_funct7 : req0_funct7;

  alu u_alu (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_in1    (w_in1),
    .i_in2    (w_in2),
    .i_funct3 (w_funct3),
    .i_funct7 (w_funct7),
    .o_out    (w_alu_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = FULL;
      FULL:    if (!w_accept && rsp_ready) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
      r_prio  <= c_START_PRIO;
      r_data  <= '0;
      r_id    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data <= w_alu_out;
        r_id   <= w_gnt_id;
        r_prio <= !w_gnt_id;
      end
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_ready) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (req1_ready) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_alu_share_arbiter : scoreboard bench for alu_share_arbiter.  Rev 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [2:0]  req0_funct3, req1_funct3;
  logic [6:0]  req0_funct7, req1_funct7;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  alu_share_arbiter #(.START_PRIO(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
    .req0_in2(req0_in2), .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
    .req1_in2(req1_in2), .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        m_valid, m_prio, m_id;
  logic [31:0] m_data;
  int          m_cnt0, m_cnt1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic [6:0] f7);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0: return (f7 == 7'h20) ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: begin
        if (f7 == 7'h20) begin
          sa = sa >>> b[4:0];
          return sa;
        end
        return a >> b[4:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic set_req(input int p, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7);
    if (p == 0) begin
      req0_valid = v; req0_in1 = a; req0_in2 = b; req0_funct3 = f3; req0_funct7 = f7;
    end else begin
      req1_valid = v; req1_in1 = a; req1_in2 = b; req1_funct3 = f3; req1_funct7 = f7;
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_prio = 1'b0; m_id = 1'b0; m_data = '0;
    m_cnt0 = 0; m_cnt1 = 0;
    q.delete();
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    logic e_can, e_any, e_gid, e_r0, e_r1;
    exp_t e;
    #1;
    e_can = !m_valid || rsp_ready;
    e_any = req0_valid || req1_valid;
    e_gid = (req0_valid && req1_valid) ? m_prio : req1_valid;
    e_r0  = e_can && e_any && !e_gid;
    e_r1  = e_can && e_any && e_gid;
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, e_r0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, e_r1});
    if (e_r0 || e_r1) begin
      e.id   = e_gid;
      e.data = e_gid ? alu_ref(req1_in1, req1_in2, req1_funct3, req1_funct7)
                     : alu_ref(req0_in1, req0_in2, req0_funct3, req0_funct7);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (e_r0 || e_r1) begin
      e = q.pop_front();
      m_valid = 1'b1; m_data = e.data; m_id = e.id; m_prio = !e.id;
      if (e.id) m_cnt1++; else m_cnt0++;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_id", {31'b0, rsp_id}, {31'b0, m_id});
    end
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", {16'b0, grant_cnt0}, m_cnt0);
    chk("grant_cnt1", {16'b0, grant_cnt1}, m_cnt1);
`endif
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd1, 32'd1, 3'd0, 7'h00);
    set_req(1, 1'b1, 32'd1, 32'd1, 3'd0, 7'h00);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_id", {31'b0, rsp_id}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_req(1, 1'b0, 0, 0, 3'd0, 7'h00);

    // Single issue on port 0: 5 + 7
    set_req(0, 1'b1, 32'd5, 32'd7, 3'd0, 7'h00);
    tick();
    chk("add_12", rsp_data, 32'd12);
    // SUB wrap on port 1
    set_req(0, 1'b0, 0, 0, 3'd0, 7'h00);
    set_req(1, 1'b1, 32'd3, 32'd5, 3'd0, 7'h20);
    tick();
    chk("sub_wrap", rsp_data, 32'hFFFF_FFFE);
    chk("sub_id", {31'b0, rsp_id}, 32'd1);

    // Contention: strict alternation, one response per cycle
    set_req(0, 1'b1, 32'd1, 32'd1, 3'd0, 7'h00);
    set_req(1, 1'b1, 32'hF0, 32'hFF, 3'd4, 7'h00);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("alt_id", {31'b0, rsp_id}, i % 2);
    end

    // Backpressure after an SRA result
    set_req(0, 1'b1, 32'h8000_0000, 32'd4, 3'd5, 7'h20);
    set_req(1, 1'b0, 0, 0, 3'd0, 7'h00);
    tick();
    chk("sra", rsp_data, 32'hF800_0000);
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 32'd9, 32'd3, 3'd1, 7'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_data", rsp_data, 32'hF800_0000);
    end
    rsp_ready = 1'b1;
    tick();

    // Reset while a response is pending
    rsp_ready = 1'b0;
    set_req(1, 1'b0, 0, 0, 3'd0, 7'h00);
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, rsp_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'd2, 32'd3, 3'd0, 7'h00);
    set_req(1, 1'b1, 32'd4, 32'd3, 3'd0, 7'h00);
    tick();
    chk("post_rst_id", {31'b0, rsp_id}, 32'd0);
    set_req(1, 1'b0, 0, 0, 3'd0, 7'h00);

    // Signed vs unsigned compare
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd2, 7'h00);
    tick();
    chk("slt", rsp_data, 32'd1);
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'd3, 7'h00);
    tick();
    chk("sltu", rsp_data, 32'd0);

    // Grant totals: 5 on port 0 (incl. above), 3 on port 1
    for (int i = 0; i < 2; i++) begin
      set_req(0, 1'b1, i, 32'hFF, 3'd7, 7'h00);
      tick();
    end
    set_req(0, 1'b0, 0, 0, 3'd0, 7'h00);
    for (int i = 0; i < 3; i++) begin
      set_req(1, 1'b1, i, 32'h10, 3'd6, 7'h00);
      tick();
    end
    set_req(1, 1'b0, 0, 0, 3'd0, 7'h00);
`ifdef ALU_ARB_STATS_EN
    chk("cnt0_total", {16'b0, grant_cnt0}, 32'd5);
    chk("cnt1_total", {16'b0, grant_cnt1}, 32'd3);
`endif
    tick();
    chk("drained", {31'b0, rsp_valid}, 32'd0);
    chk("queue_empty", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
